// File: rtl/ddr_sequencer.sv
// Command scheduler for the DDR controller: arbitrates refresh, write and read requests,
// then drives the start/exec handshake and walks the column address through a burst.
module ddr_sequencer #(
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 8,
  parameter int LEN_W  = 4
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              init_done_i,
  input  logic              wr_req_i,
  input  logic [BANK_W-1:0] wr_bank_i,
  input  logic [ROW_W-1:0]  wr_row_i,
  input  logic [COL_W-1:0]  wr_col_i,
  input  logic [LEN_W-1:0]  wr_len_i,
  output logic              wr_ack_o,
  input  logic              rd_req_i,
  input  logic [BANK_W-1:0] rd_bank_i,
  input  logic [ROW_W-1:0]  rd_row_i,
  input  logic [COL_W-1:0]  rd_col_i,
  input  logic [LEN_W-1:0]  rd_len_i,
  output logic              rd_ack_o,
  output logic              busy_o,
  output logic              cmd_start_o,
  output logic              cmd_read_o,
  output logic              cmd_last_o,
  input  logic              cmd_exec_i,
  input  logic              cmd_active_i,
  output logic [BANK_W-1:0] cmd_bank_o,
  output logic [ROW_W-1:0]  cmd_row_o,
  output logic [COL_W-1:0]  cmd_col_o,
  input  logic              rfc_req_i,
  output logic              rfc_start_o,
  input  logic              rfc_done_i
);

  typedef enum logic [2:0] {IDLE, REFRESH, START, BURST, DRAIN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W:0]   rem;
  logic             grant_rfc;
  logic             grant_wr;
  logic             grant_rd;
  logic             col_step;
  logic             rem_one;

  assign rem_one    = (rem == (LEN_W+1)'(1));
  assign busy_o     = (state != IDLE);
  // Last flag is combinational from the remaining count so it lines up with the final exec.
  assign cmd_last_o = ((state == BURST) && rem_one) || (state == DRAIN);

  always_ff @(posedge clock_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_rfc = 1'b0;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    col_step  = 1'b0;
    case (state)
      IDLE: begin
        if (init_done_i) begin
          if (rfc_req_i) begin
            grant_rfc = 1'b1;
            state_nxt = REFRESH;
          end else if (wr_req_i) begin
            grant_wr  = 1'b1;
            state_nxt = START;
          end else if (rd_req_i) begin
            grant_rd  = 1'b1;
            state_nxt = START;
          end
        end
      end
      REFRESH: if (rfc_done_i) state_nxt = IDLE;
      START:   state_nxt = BURST;
      BURST: begin
        if (cmd_exec_i) begin
          col_step = 1'b1;
          if (rem_one) state_nxt = DRAIN;
        end
      end
      DRAIN:   if (!cmd_active_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ack_o    <= 1'b0;
      rd_ack_o    <= 1'b0;
      rfc_start_o <= 1'b0;
      cmd_start_o <= 1'b0;
      cmd_read_o  <= 1'b0;
      cmd_bank_o  <= '0;
      cmd_row_o   <= '0;
      cmd_col_o   <= '0;
      rem         <= '0;
    end else begin
      wr_ack_o    <= grant_wr;
      rd_ack_o    <= grant_rd;
      rfc_start_o <= grant_rfc;
      cmd_start_o <= (state == START);
      if (grant_wr) begin
        cmd_bank_o <= wr_bank_i;
        cmd_row_o  <= wr_row_i;
        cmd_col_o  <= wr_col_i;
        rem        <= {1'b0, wr_len_i} + (LEN_W+1)'(1);
        cmd_read_o <= 1'b0;
      end else if (grant_rd) begin
        cmd_bank_o <= rd_bank_i;
        cmd_row_o  <= rd_row_i;
        cmd_col_o  <= rd_col_i;
        rem        <= {1'b0, rd_len_i} + (LEN_W+1)'(1);
        cmd_read_o <= 1'b1;
      end
      // Column wraps inside the open row; bank and row are never touched mid-burst.
      if (col_step) begin
        cmd_col_o <= cmd_col_o + COL_W'(1);
        rem       <= rem - (LEN_W+1)'(1);
      end
    end
  end

endmodule

// File: tb/tb_ddr_sequencer.sv
// Directed bench for ddr_sequencer: arbitration order, burst column walk, refresh hold-off
// and mid-burst reset, each step checked against hand-computed values.
module tb_ddr_sequencer;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        init_done_i = 1'b0;
  logic        wr_req_i = 1'b0;
  logic [1:0]  wr_bank_i = '0;
  logic [12:0] wr_row_i = '0;
  logic [7:0]  wr_col_i = '0;
  logic [3:0]  wr_len_i = '0;
  logic        wr_ack_o;
  logic        rd_req_i = 1'b0;
  logic [1:0]  rd_bank_i = '0;
  logic [12:0] rd_row_i = '0;
  logic [7:0]  rd_col_i = '0;
  logic [3:0]  rd_len_i = '0;
  logic        rd_ack_o;
  logic        busy_o;
  logic        cmd_start_o;
  logic        cmd_read_o;
  logic        cmd_last_o;
  logic        cmd_exec_i = 1'b0;
  logic        cmd_active_i = 1'b0;
  logic [1:0]  cmd_bank_o;
  logic [12:0] cmd_row_o;
  logic [7:0]  cmd_col_o;
  logic        rfc_req_i = 1'b0;
  logic        rfc_start_o;
  logic        rfc_done_i = 1'b0;

  int tests  = 0;
  int failed = 0;

  ddr_sequencer dut (
    .clock_i(clock_i), .reset_i(reset_i), .init_done_i(init_done_i),
    .wr_req_i(wr_req_i), .wr_bank_i(wr_bank_i), .wr_row_i(wr_row_i),
    .wr_col_i(wr_col_i), .wr_len_i(wr_len_i), .wr_ack_o(wr_ack_o),
    .rd_req_i(rd_req_i), .rd_bank_i(rd_bank_i), .rd_row_i(rd_row_i),
    .rd_col_i(rd_col_i), .rd_len_i(rd_len_i), .rd_ack_o(rd_ack_o),
    .busy_o(busy_o), .cmd_start_o(cmd_start_o), .cmd_read_o(cmd_read_o),
    .cmd_last_o(cmd_last_o), .cmd_exec_i(cmd_exec_i), .cmd_active_i(cmd_active_i),
    .cmd_bank_o(cmd_bank_o), .cmd_row_o(cmd_row_o), .cmd_col_o(cmd_col_o),
    .rfc_req_i(rfc_req_i), .rfc_start_o(rfc_start_o), .rfc_done_i(rfc_done_i)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and init gating
    tick(); tick();
    reset_i = 1'b0;
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_outs", 32'({wr_ack_o, rd_ack_o, cmd_start_o, cmd_read_o, cmd_last_o, rfc_start_o}), 0);
    chk("rst_addr", 32'({cmd_bank_o, cmd_row_o, cmd_col_o}), 0);
    wr_req_i = 1'b1; wr_bank_i = 2'd1; wr_row_i = 13'h155; wr_col_i = 8'h10; wr_len_i = 4'd3;
    tick();
    chk("noinit_ack", 32'(wr_ack_o), 0);
    tick();
    chk("noinit_ack2", 32'(wr_ack_o), 0);
    chk("noinit_busy", 32'(busy_o), 0);
    init_done_i = 1'b1;
    tick();
    chk("wr_ack", 32'(wr_ack_o), 1);
    chk("wr_ack_start", 32'(cmd_start_o), 0);
    chk("wr_ack_busy", 32'(busy_o), 1);
    wr_req_i = 1'b0;
    tick();
    chk("wr_ack_drop", 32'(wr_ack_o), 0);
    chk("wr_start", 32'(cmd_start_o), 1);
    chk("wr_read", 32'(cmd_read_o), 0);
    chk("wr_bank", 32'(cmd_bank_o), 1);
    chk("wr_row", 32'(cmd_row_o), 'h155);
    chk("wr_last0", 32'(cmd_last_o), 0);
    cmd_active_i = 1'b1;
    tick();
    chk("wr_start_pulse", 32'(cmd_start_o), 0);

    // Four-column write burst
    for (int i = 0; i < 4; i++) begin
      cmd_exec_i = 1'b1;
      chk("wr_col", 32'(cmd_col_o), 32'('h10 + i));
      chk("wr_last", 32'(cmd_last_o), 32'(i == 3));
      tick();
    end
    cmd_exec_i = 1'b0;
    chk("drain_last", 32'(cmd_last_o), 1);
    chk("drain_busy", 32'(busy_o), 1);
    tick();
    chk("drain_hold", 32'(cmd_last_o), 1);
    cmd_active_i = 1'b0;
    tick();
    chk("wr_idle_busy", 32'(busy_o), 0);
    chk("wr_idle_last", 32'(cmd_last_o), 0);
    cmd_exec_i = 1'b1;
    tick();
    cmd_exec_i = 1'b0;
    chk("idle_exec_col", 32'(cmd_col_o), 'h14);

    // Read burst wrapping the column inside the row
    rd_req_i = 1'b1; rd_bank_i = 2'd2; rd_row_i = 13'h0AB; rd_col_i = 8'hFE; rd_len_i = 4'd2;
    tick();
    chk("rd_ack", 32'(rd_ack_o), 1);
    chk("rd_ack_wr", 32'(wr_ack_o), 0);
    rd_req_i = 1'b0;
    tick();
    chk("rd_start", 32'(cmd_start_o), 1);
    chk("rd_read", 32'(cmd_read_o), 1);
    chk("rd_bank", 32'(cmd_bank_o), 2);
    cmd_active_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      cmd_exec_i = 1'b1;
      chk("rd_col", 32'(cmd_col_o), 32'((254 + i) % 256));
      chk("rd_row", 32'(cmd_row_o), 'h0AB);
      chk("rd_last", 32'(cmd_last_o), 32'(i == 2));
      tick();
    end
    cmd_exec_i = 1'b0;
    cmd_active_i = 1'b0;
    chk("rd_drain", 32'(cmd_last_o), 1);
    chk("rd_read_hold", 32'(cmd_read_o), 1);
    tick();
    chk("rd_idle", 32'(busy_o), 0);
    chk("rd_bank_keep", 32'(cmd_bank_o), 2);

    // Simultaneous refresh, write and read
    rfc_req_i = 1'b1;
    wr_req_i = 1'b1; wr_bank_i = 2'd3; wr_row_i = 13'h1FFF; wr_col_i = 8'h20; wr_len_i = 4'd1;
    rd_req_i = 1'b1; rd_bank_i = 2'd0; rd_row_i = 13'h001; rd_col_i = 8'h40; rd_len_i = 4'd0;
    tick();
    chk("tri_rfc", 32'(rfc_start_o), 1);
    chk("tri_acks", 32'({wr_ack_o, rd_ack_o}), 0);
    rfc_req_i = 1'b0;
    tick();
    chk("tri_rfc_pulse", 32'(rfc_start_o), 0);
    chk("tri_refresh_acks", 32'({wr_ack_o, rd_ack_o}), 0);
    tick();
    chk("tri_refresh_busy", 32'(busy_o), 1);
    rfc_done_i = 1'b1;
    tick();
    rfc_done_i = 1'b0;
    chk("tri_back_idle", 32'(busy_o), 0);
    chk("tri_no_ack_yet", 32'({wr_ack_o, rd_ack_o}), 0);
    tick();
    chk("tri_wr_ack", 32'({wr_ack_o, rd_ack_o}), 'b10);
    wr_req_i = 1'b0;
    tick();
    chk("tri_wr_start", 32'(cmd_start_o), 1);
    chk("tri_wr_read", 32'(cmd_read_o), 0);
    chk("tri_wr_bank", 32'(cmd_bank_o), 3);
    cmd_active_i = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      cmd_exec_i = 1'b1;
      chk("tri_col", 32'(cmd_col_o), 32'('h20 + i));
      chk("tri_last", 32'(cmd_last_o), 32'(i == 1));
      chk("tri_rd_wait", 32'(rd_ack_o), 0);
      tick();
    end
    cmd_exec_i = 1'b0;
    cmd_active_i = 1'b0;
    tick();
    chk("tri_rd_wait_idle", 32'(rd_ack_o), 0);
    tick();
    chk("tri_rd_ack", 32'(rd_ack_o), 1);
    rd_req_i = 1'b0;
    tick();
    chk("len0_start", 32'(cmd_start_o), 1);
    chk("len0_read", 32'(cmd_read_o), 1);
    chk("len0_addr", 32'({cmd_bank_o, cmd_row_o, cmd_col_o}), 32'({2'd0, 13'h001, 8'h40}));
    chk("len0_last", 32'(cmd_last_o), 1);
    cmd_active_i = 1'b1;
    cmd_exec_i = 1'b1;
    tick();
    cmd_exec_i = 1'b0;
    cmd_active_i = 1'b0;
    chk("len0_drain", 32'(cmd_last_o), 1);
    tick();
    chk("len0_idle", 32'(busy_o), 0);

    // Refresh raised mid-burst with a read pending
    wr_req_i = 1'b1; wr_bank_i = 2'd1; wr_row_i = 13'h010; wr_col_i = 8'h80; wr_len_i = 4'd1;
    tick();
    chk("mid_wr_ack", 32'(wr_ack_o), 1);
    wr_req_i = 1'b0;
    tick();
    cmd_active_i = 1'b1;
    rfc_req_i = 1'b1;
    rd_req_i = 1'b1; rd_bank_i = 2'd2; rd_row_i = 13'h022; rd_col_i = 8'h05; rd_len_i = 4'd0;
    tick();
    chk("mid_no_rfc", 32'(rfc_start_o), 0);
    cmd_exec_i = 1'b1;
    chk("mid_col0", 32'(cmd_col_o), 'h80);
    chk("mid_last0", 32'(cmd_last_o), 0);
    tick();
    chk("mid_no_rfc2", 32'(rfc_start_o), 0);
    chk("mid_col1", 32'(cmd_col_o), 'h81);
    chk("mid_last1", 32'(cmd_last_o), 1);
    tick();
    cmd_exec_i = 1'b0;
    chk("mid_drain_rfc", 32'({rfc_start_o, rd_ack_o}), 0);
    cmd_active_i = 1'b0;
    tick();
    chk("mid_idle_rfc", 32'({rfc_start_o, rd_ack_o}), 0);
    tick();
    chk("mid_rfc_first", 32'({rfc_start_o, rd_ack_o}), 'b10);
    rfc_req_i = 1'b0;
    rfc_done_i = 1'b1;
    tick();
    rfc_done_i = 1'b0;
    chk("mid_rfc_done", 32'({rfc_start_o, rd_ack_o}), 0);
    tick();
    chk("mid_rd_ack", 32'(rd_ack_o), 1);
    rd_req_i = 1'b0;
    tick();
    chk("mid_rd_start", 32'(cmd_start_o), 1);
    chk("mid_rd_col", 32'(cmd_col_o), 'h05);
    cmd_active_i = 1'b1;
    tick();

    // Reset while in BURST, with a read request outstanding
    rd_req_i = 1'b1;
    reset_i = 1'b1;
    tick();
    chk("rb_busy", 32'(busy_o), 0);
    chk("rb_outs", 32'({wr_ack_o, rd_ack_o, cmd_start_o, cmd_read_o, cmd_last_o, rfc_start_o}), 0);
    chk("rb_addr", 32'({cmd_bank_o, cmd_row_o, cmd_col_o}), 0);
    reset_i = 1'b0;
    rd_req_i = 1'b0;
    cmd_active_i = 1'b0;
    tick();
    chk("rb_no_ack", 32'(rd_ack_o), 0);
    wr_req_i = 1'b1; wr_bank_i = 2'd1; wr_row_i = 13'h007; wr_col_i = 8'h03; wr_len_i = 4'd0;
    tick();
    chk("rb_wr_ack", 32'(wr_ack_o), 1);
    wr_req_i = 1'b0;
    tick();
    chk("rb_start", 32'(cmd_start_o), 1);
    chk("rb_addr2", 32'({cmd_bank_o, cmd_row_o, cmd_col_o}), 32'({2'd1, 13'h007, 8'h03}));
    chk("rb_last", 32'(cmd_last_o), 1);
    cmd_active_i = 1'b1;
    cmd_exec_i = 1'b1;
    tick();
    cmd_exec_i = 1'b0;
    cmd_active_i = 1'b0;
    tick();
    chk("rb_idle", 32'(busy_o), 0);
    chk("rb_col_end", 32'(cmd_col_o), 'h04);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
